vrf_op_sequencer: RTL and testbench
===================================

Name: vrf_op_sequencer

Overview:
- Sits directly downstream of the instruction launcher's operand-request port, and takes the place of the read-issue half of the VRF accessor.
- Accepts one operand request at a time and expands it into a sequence of VRF word reads for each requested operand queue.
- Round-robin arbitrates those reads onto a single VRF read port and pushes the returned data into the operand queues.
- Pulses per-queue access-done with the source register so the scoreboard can release read hazards.

Parameters:
- NrOpQueue, 2: number of operand queues. Queue 0 sources vs1, queue 1 sources vs2.
- VLENB, 16: bytes per vector register.
- DataWB, 8: bytes per VRF word. WordsPerVReg = VLENB/DataWB, which must be a power of two.
- VRFAddrW, 6: VRF word address width, equal to $clog2(32*WordsPerVReg).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- op_req_valid_i  in  1  operand request valid
- op_req_ready_o  out  1  sequencer can accept a request
- op_req_i  in  $bits(op_req_t)  request; fields vs1, vs2 (vreg_t, 5b), queue_req [NrOpQueue-1:0], vlB
- vrf_rd_req_o  out  1  VRF read request
- vrf_rd_addr_o  out  VRFAddrW  VRF read word address
- vrf_rd_gnt_i  in  1  read granted this cycle
- vrf_rd_data_i  in  8*DataWB  read data, valid the cycle after a grant
- opq_ready_i  in  NrOpQueue  queue q guarantees it accepts a push in the following cycle
- opq_push_o  out  NrOpQueue  push strobe per queue
- opq_data_o  out  8*DataWB  push data, shared by all queues
- op_access_done_o  out  NrOpQueue  one-cycle pulse on the last push for queue q
- op_access_vs_o  out  NrOpQueue*5  source register of queue q, held between requests
- perf_stall_cnt_o  out  32  see Optional Feature

Behaviour:
- Reset values: all outputs 0; op_req_ready_o becomes 1 on the first clock after reset release. FSM is IDLE, all counters 0, rr pointer 0.
- FSM states:
  - IDLE: op_req_ready_o=1.
  - On op_req_valid_i && ready, latch vs1/vs2 into op_access_vs_o and set the active mask to queue_req.
  - Set the remaining-word count per active queue to nwords = ceil(vlB/DataWB), computed with VlB-width+1 arithmetic. The word index is cleared.
  - Move to READ, or to ZERO if vlB==0.
  - If queue_req==0: the request is accepted and consumed, no pushes, no done pulses, and the FSM stays in IDLE.
- ZERO: pulse op_access_done_o[q] for every active q for one cycle, then go to IDLE. op_req_ready_o=0.
- READ: op_req_ready_o=0.
  - A queue is eligible if it is active, has words left, and opq_ready_i[q]=1.
  - Round-robin select starting at the rr pointer. Drive vrf_rd_req_o=1 and vrf_rd_addr_o = src_reg*WordsPerVReg + word_idx[q], truncated to VRFAddrW.
  - The request and address stay stable until granted or until eligibility drops. Deasserting the request without a grant is legal.
  - On grant: decrement the queue's remaining count, increment its index, set rr = granted+1 mod NrOpQueue, and record the in-flight queue id.
  - Cycle after a grant: opq_push_o[id]=1 and opq_data_o=vrf_rd_data_i. If this is the queue's last word, op_access_done_o[id]=1 in the same cycle.
  - When all active queues have pushed their last word, go to IDLE on the next cycle. At most one grant per cycle, so back-to-back grants give full throughput.
- Tail words are pushed as whole words; downstream masks them using vlB.
- Address wrap: index never exceeds WordsPerVReg-1 for legal vlB ≤ VLENB. vlB > VLENB is illegal and its behaviour is unspecified.
- Simultaneous events: a push for queue A and a grant for queue B in the same cycle is legal.
- A done pulse for a queue and its opq_ready_i going low in the same cycle has no effect.
- Reset mid-operation: asynchronous clear. In-flight data is dropped, no done pulses are produced, and the FSM returns to IDLE.

Optional Feature:
- Macro OP_SEQ_PERF_EN.
- When defined: a 32-bit saturating counter increments each READ cycle in which an active queue with words left has opq_ready_i=0, or in which vrf_rd_req_o=1 && !vrf_rd_gnt_i.
  - The counter clears only on reset and saturates at 32'hFFFFFFFF. It drives perf_stall_cnt_o.
- When undefined: perf_stall_cnt_o is constant 0 and no counter logic exists.

Test Plan (VLENB=16, DataWB=8):
- vs1=3, queue_req=2'b01, vlB=16, grant always, ready always -> addresses 6,7 on cycles t+1,t+2. Pushes on t+2,t+3. done[0] at t+3 with vs_o[0]=3. Ready again at t+4.
- queue_req=2'b11, vs1=1, vs2=4, vlB=9 -> interleaved addresses 2,8,3,9 with rr alternation. done[0] and done[1] on the respective last pushes.
- vlB=0, queue_req=2'b11 -> no vrf_rd_req. done=2'b11 for exactly one cycle, then IDLE.
- opq_ready_i[1]=0 for 5 cycles mid-request, queue_req=2'b10, vlB=16 -> no reads for queue 1 during the stall. perf_stall_cnt_o=5 with the macro defined, 0 without.
- vrf_rd_gnt_i withheld 3 cycles -> address held stable, no push, no count loss.
- rst_ni asserted mid-READ -> all outputs 0 immediately; next request completes normally.

Source files
------------

// File: rtl/vrf_op_sequencer.sv
// Expands one operand request into per-queue VRF word reads, round-robin on one read port.
// Optional stall counter enabled by defining OP_SEQ_PERF_EN.
module vrf_op_sequencer #(
  parameter int unsigned NrOpQueue = 2,
  parameter int unsigned VLENB     = 16,
  parameter int unsigned DataWB    = 8,
  parameter int unsigned VRFAddrW  = 6,
  parameter int unsigned VlBW      = $clog2(VLENB) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      op_req_valid_i,
  output logic                      op_req_ready_o,
  input  logic [10+NrOpQueue+VlBW-1:0] op_req_i,
  output logic                      vrf_rd_req_o,
  output logic [VRFAddrW-1:0]       vrf_rd_addr_o,
  input  logic                      vrf_rd_gnt_i,
  input  logic [8*DataWB-1:0]       vrf_rd_data_i,
  input  logic [NrOpQueue-1:0]      opq_ready_i,
  output logic [NrOpQueue-1:0]      opq_push_o,
  output logic [8*DataWB-1:0]       opq_data_o,
  output logic [NrOpQueue-1:0]      op_access_done_o,
  output logic [NrOpQueue*5-1:0]    op_access_vs_o,
  output logic [31:0]               perf_stall_cnt_o
);

  localparam int unsigned Words = VLENB / DataWB;
  localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned QW    = (NrOpQueue > 1) ? $clog2(NrOpQueue) : 1;
  localparam int unsigned CntW  = VlBW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ZERO = 2'd1;
  localparam logic [1:0] READ = 2'd2;

  typedef struct packed {
    logic [4:0]           vs1;
    logic [4:0]           vs2;
    logic [NrOpQueue-1:0] queue_req;
    logic [VlBW-1:0]      vlB;
  } op_req_t;

  op_req_t req;
  assign req = op_req_t'(op_req_i);

  logic [1:0]                           state_q, state_d;
  logic                                 rdy_en_q;
  logic [NrOpQueue-1:0]                 act_q, act_d;
  logic [NrOpQueue-1:0][CntW-1:0]       rem_q, rem_d;
  logic [NrOpQueue-1:0][IdxW-1:0]       idx_q, idx_d;
  logic [NrOpQueue-1:0][4:0]            vs_q, vs_d;
  logic [QW-1:0]                        rr_q, rr_d;
  logic                                 push_q, push_d;
  logic [QW-1:0]                        push_id_q, push_id_d;
  logic                                 last_q, last_d;

  logic [NrOpQueue-1:0] elig;
  logic [QW-1:0]        sel, cand;
  logic                 sel_vld;
  logic [CntW-1:0]      nwords;

  // Scan from the highest offset down so the first eligible queue after rr wins.
  always_comb begin
    elig    = '0;
    sel     = rr_q;
    sel_vld = 1'b0;
    cand    = '0;
    for (int q = 0; q < NrOpQueue; q++) begin
      elig[q] = act_q[q] && (rem_q[q] != '0) && opq_ready_i[q];
    end
    for (int i = NrOpQueue - 1; i >= 0; i--) begin
      cand = QW'((32'(rr_q) + 32'(i)) % NrOpQueue);
      if (elig[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  assign vrf_rd_req_o   = (state_q == READ) && sel_vld;
  assign vrf_rd_addr_o  = vrf_rd_req_o
                        ? VRFAddrW'(vs_q[sel]) * VRFAddrW'(Words)
                          + VRFAddrW'(idx_q[sel])
                        : '0;
  assign op_req_ready_o = rdy_en_q && (state_q == IDLE);
  assign op_access_vs_o = vs_q;
  assign opq_data_o     = push_q ? vrf_rd_data_i : '0;
  assign nwords         = ({1'b0, req.vlB} + CntW'(DataWB - 1))
                        / CntW'(DataWB);

  always_comb begin
    opq_push_o       = '0;
    op_access_done_o = '0;
    if (push_q) opq_push_o[push_id_q] = 1'b1;
    if (push_q && last_q) op_access_done_o[push_id_q] = 1'b1;
    if (state_q == ZERO) op_access_done_o = act_q;
  end

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    vs_d      = vs_q;
    rr_d      = rr_q;
    push_d    = 1'b0;
    push_id_d = push_id_q;
    last_d    = last_q;
    unique case (state_q)
      IDLE: begin
        if (op_req_valid_i && op_req_ready_o) begin
          act_d = req.queue_req;
          for (int q = 0; q < NrOpQueue; q++) begin
            vs_d[q]  = (q == 0) ? req.vs1 : req.vs2;
            rem_d[q] = req.queue_req[q] ? nwords : '0;
            idx_d[q] = '0;
          end
          if (req.queue_req != '0) begin
            state_d = (req.vlB == '0) ? ZERO : READ;
          end
        end
      end
      ZERO: state_d = IDLE;
      READ: begin
        // Counts hit zero at grant, so the final push sees all of them clear.
        if (push_q && (rem_q == '0)) state_d = IDLE;
        if (vrf_rd_req_o && vrf_rd_gnt_i) begin
          rem_d[sel] = rem_q[sel] - 1'b1;
          idx_d[sel] = idx_q[sel] + 1'b1;
          rr_d       = (32'(sel) == NrOpQueue - 1) ? '0 : sel + 1'b1;
          push_d     = 1'b1;
          push_id_d  = sel;
          last_d     = (rem_q[sel] == CntW'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rdy_en_q  <= 1'b0;
      act_q     <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      vs_q      <= '0;
      rr_q      <= '0;
      push_q    <= 1'b0;
      push_id_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_en_q  <= 1'b1;
      act_q     <= act_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      vs_q      <= vs_d;
      rr_q      <= rr_d;
      push_q    <= push_d;
      push_id_q <= push_id_d;
      last_q    <= last_d;
    end
  end

`ifdef OP_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        stall;

  always_comb begin
    stall = vrf_rd_req_o && !vrf_rd_gnt_i;
    for (int q = 0; q < NrOpQueue; q++) begin
      if (act_q[q] && (rem_q[q] != '0) && !opq_ready_i[q]) stall = 1'b1;
    end
    perf_d = perf_q;
    if ((state_q == READ) && stall && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_stall_cnt_o = perf_q;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vrf_op_sequencer.sv
// Directed bench for vrf_op_sequencer with a cycle-level reference model.
// Outputs compared every cycle on the falling edge; inputs change 1 time unit after rising edge.
module tb_vrf_op_sequencer;

  localparam int NQ = 2;

  localparam bit PERF =
`ifdef OP_SEQ_PERF_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        op_req_valid_i = 1'b0;
  logic        op_req_ready_o;
  logic [16:0] op_req_i = '0;
  logic        vrf_rd_req_o;
  logic [5:0]  vrf_rd_addr_o;
  logic        vrf_rd_gnt_i = 1'b1;
  logic [63:0] vrf_rd_data_i = '0;
  logic [1:0]  opq_ready_i = 2'b11;
  logic [1:0]  opq_push_o;
  logic [63:0] opq_data_o;
  logic [1:0]  op_access_done_o;
  logic [9:0]  op_access_vs_o;
  logic [31:0] perf_stall_cnt_o;

  vrf_op_sequencer dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .op_req_valid_i   (op_req_valid_i),
    .op_req_ready_o   (op_req_ready_o),
    .op_req_i         (op_req_i),
    .vrf_rd_req_o     (vrf_rd_req_o),
    .vrf_rd_addr_o    (vrf_rd_addr_o),
    .vrf_rd_gnt_i     (vrf_rd_gnt_i),
    .vrf_rd_data_i    (vrf_rd_data_i),
    .opq_ready_i      (opq_ready_i),
    .opq_push_o       (opq_push_o),
    .opq_data_o       (opq_data_o),
    .op_access_done_o (op_access_done_o),
    .op_access_vs_o   (op_access_vs_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mem(input int a);
    logic [5:0] a6;
    a6 = a[5:0];
    return {8{2'b10, a6}};
  endfunction

  // Reference model state
  bit          m_rdy_en = 0, m_busy = 0, m_zero = 0;
  bit [1:0]    m_act = '0;
  int          m_left[NQ], m_next[NQ], m_vs[NQ];
  int          m_rr = 0, m_inf_q = 0, m_inf_addr = 0;
  bit          m_inf = 0, m_inf_last = 0;
  logic [31:0] m_perf = '0;

  logic [63:0] nxt_data = '0;
  int gnt_log[$], wait_log[$], done_log[$], done_cyc[$];
  int last_acc = 0, rdy_rise = 0;
  bit prev_rdy = 0;

  always @(negedge clk) begin
    int p, c, e_addr, nw;
    bit e_req, e_rdy, stall, new_inf;
    logic [1:0] e_push, e_done;
    cyc++;
    if (!rst_ni) begin
      m_rdy_en = 0; m_busy = 0; m_zero = 0; m_act = '0;
      m_rr = 0; m_inf = 0; m_perf = '0;
      for (int q = 0; q < NQ; q++) begin
        m_left[q] = 0; m_next[q] = 0; m_vs[q] = 0;
      end
      prev_rdy = 0;
      chk("rst_ctl", {op_req_ready_o, vrf_rd_req_o, vrf_rd_addr_o,
          opq_push_o, op_access_done_o, op_access_vs_o}, '0);
      chk("rst_data", opq_data_o, '0);
      chk("rst_perf", perf_stall_cnt_o, '0);
    end else begin
      e_rdy = m_rdy_en && !m_busy && !m_zero;
      p = -1;
      if (m_busy) begin
        for (int i = 0; i < NQ; i++) begin
          c = (m_rr + i) % NQ;
          if (p < 0 && m_act[c] && m_left[c] > 0 && opq_ready_i[c]) p = c;
        end
      end
      e_req  = (p >= 0);
      e_addr = e_req ? (m_vs[p] * 2 + m_next[p]) % 64 : 0;
      e_push = m_inf ? 2'(1 << m_inf_q) : 2'b00;
      e_done = m_zero ? m_act : ((m_inf && m_inf_last) ? e_push : 2'b00);

      chk("ready", op_req_ready_o, e_rdy);
      chk("rd_req", vrf_rd_req_o, e_req);
      if (e_req) chk("rd_addr", vrf_rd_addr_o, e_addr);
      chk("push", opq_push_o, e_push);
      if (m_inf) chk("push_data", opq_data_o, mem(m_inf_addr));
      chk("done", op_access_done_o, e_done);
      chk("vs", op_access_vs_o, {5'(m_vs[1]), 5'(m_vs[0])});
      chk("perf", perf_stall_cnt_o, PERF ? m_perf : 32'd0);

      if (op_req_valid_i && op_req_ready_o) last_acc = cyc;
      if (vrf_rd_req_o && vrf_rd_gnt_i) gnt_log.push_back(int'(vrf_rd_addr_o));
      if (vrf_rd_req_o && !vrf_rd_gnt_i) wait_log.push_back(int'(vrf_rd_addr_o));
      if (op_access_done_o != 0) begin
        done_log.push_back(int'(op_access_done_o));
        done_cyc.push_back(cyc);
      end
      if (op_req_ready_o && !prev_rdy) rdy_rise = cyc;
      prev_rdy = op_req_ready_o;

      stall = e_req && !vrf_rd_gnt_i;
      for (int q = 0; q < NQ; q++) begin
        if (m_act[q] && m_left[q] > 0 && !opq_ready_i[q]) stall = 1;
      end
      if (m_busy && stall && m_perf != 32'hFFFF_FFFF) m_perf++;

      new_inf = 0;
      if (m_busy) begin
        if (m_inf && m_left[0] == 0 && m_left[1] == 0) m_busy = 0;
        if (e_req && vrf_rd_gnt_i) begin
          m_left[p]--;
          m_next[p]++;
          m_rr       = (p + 1) % NQ;
          new_inf    = 1;
          m_inf_q    = p;
          m_inf_addr = e_addr;
          m_inf_last = (m_left[p] == 0);
        end
      end else if (m_zero) begin
        m_zero = 0;
      end else if (op_req_valid_i && e_rdy) begin
        m_vs[0] = int'(op_req_i[16:12]);
        m_vs[1] = int'(op_req_i[11:7]);
        m_act   = op_req_i[6:5];
        nw      = (int'(op_req_i[4:0]) + 7) / 8;
        for (int q = 0; q < NQ; q++) begin
          m_left[q] = m_act[q] ? nw : 0;
          m_next[q] = 0;
        end
        if (m_act != 0) begin
          if (op_req_i[4:0] == 0) m_zero = 1;
          else m_busy = 1;
        end
      end
      m_inf    = new_inf;
      m_rdy_en = 1;
    end
    nxt_data = (vrf_rd_req_o && vrf_rd_gnt_i)
             ? mem(int'(vrf_rd_addr_o)) : 64'hDEAD_BEEF_0BAD_F00D;
  end

  // VRF read port responder: data follows a grant by one cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      vrf_rd_data_i = nxt_data;
    end
  end

  task automatic send(input int vs1, input int vs2, input logic [1:0] q,
                      input int vlb);
    bit ok;
    ok = 0;
    op_req_i = {5'(vs1), 5'(vs2), q, 5'(vlb)};
    op_req_valid_i = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (op_req_ready_o) ok = 1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    op_req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (op_req_ready_o) ok = 1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_seq(input string name, input int got[$], input int n,
                         input int e0, input int e1, input int e2,
                         input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({name, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk(name, got[i], e[i]);
  endtask

  initial begin
    int gb, db;
    logic [31:0] p0;
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Two queues interleaved, rr starts at 0
    gb = gnt_log.size(); db = done_log.size();
    send(1, 4, 2'b11, 9);
    wait_idle(40);
    chk_seq("t2_addr", gnt_log[gb:$], 4, 2, 8, 3, 9);
    chk_seq("t2_done", done_log[db:$], 2, 1, 2, 0, 0);
    if (done_cyc.size() > db + 1) begin
      chk("t2_done0_ofs", done_cyc[db] - last_acc, 4);
      chk("t2_done1_ofs", done_cyc[db+1] - last_acc, 5);
    end
    chk("t2_rdy_ofs", rdy_rise - last_acc, 6);

    // Single queue, full register
    gb = gnt_log.size(); db = done_log.size();
    send(3, 0, 2'b01, 16);
    wait_idle(40);
    chk_seq("t1_addr", gnt_log[gb:$], 2, 6, 7, 0, 0);
    chk_seq("t1_done", done_log[db:$], 1, 1, 0, 0, 0);
    if (done_cyc.size() > db) chk("t1_done_ofs", done_cyc[db] - last_acc, 3);
    chk("t1_rdy_ofs", rdy_rise - last_acc, 4);
    chk("t1_vs0", op_access_vs_o[4:0], 3);

    // Zero-length request
    gb = gnt_log.size(); db = done_log.size();
    send(0, 0, 2'b11, 0);
    wait_idle(20);
    chk("t3_no_reads", gnt_log.size() - gb, 0);
    chk_seq("t3_done", done_log[db:$], 1, 3, 0, 0, 0);
    if (done_cyc.size() > db) chk("t3_done_ofs", done_cyc[db] - last_acc, 1);
    chk("t3_rdy_ofs", rdy_rise - last_acc, 2);

    // Empty queue mask is consumed silently
    gb = gnt_log.size(); db = done_log.size();
    send(5, 5, 2'b00, 16);
    @(negedge clk);
    chk("t7_ready", op_req_ready_o, 1);
    chk("t7_no_reads", gnt_log.size() - gb, 0);
    chk("t7_no_done", done_log.size() - db, 0);
    @(posedge clk);
    #1;

    // Queue 1 back-pressure for 5 cycles after its first read
    p0 = perf_stall_cnt_o;
    gb = gnt_log.size(); db = done_log.size();
    send(0, 5, 2'b10, 16);
    @(posedge clk);
    #1;
    opq_ready_i = 2'b01;
    repeat (5) @(posedge clk);
    #1;
    opq_ready_i = 2'b11;
    wait_idle(40);
    chk_seq("t4_addr", gnt_log[gb:$], 2, 10, 11, 0, 0);
    chk_seq("t4_done", done_log[db:$], 1, 2, 0, 0, 0);
    chk("t4_perf_delta", perf_stall_cnt_o - p0, PERF ? 5 : 0);

    // Grant withheld for 3 cycles
    p0 = perf_stall_cnt_o;
    gb = gnt_log.size(); db = wait_log.size();
    vrf_rd_gnt_i = 1'b0;
    send(7, 0, 2'b01, 16);
    repeat (3) @(posedge clk);
    #1;
    vrf_rd_gnt_i = 1'b1;
    wait_idle(40);
    chk_seq("t5_addr", gnt_log[gb:$], 2, 14, 15, 0, 0);
    chk_seq("t5_held", wait_log[db:$], 3, 14, 14, 14, 0);
    chk("t5_perf_delta", perf_stall_cnt_o - p0, PERF ? 3 : 0);

    // Reset in the middle of a read sequence
    db = done_log.size();
    send(2, 3, 2'b11, 16);
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    @(negedge clk);
    chk("t6_rst_ctl", {op_req_ready_o, vrf_rd_req_o, opq_push_o,
        op_access_done_o, op_access_vs_o}, '0);
    chk("t6_rst_perf", perf_stall_cnt_o, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    chk("t6_no_done", done_log.size() - db, 0);
    gb = gnt_log.size();
    send(9, 0, 2'b01, 8);
    wait_idle(40);
    chk_seq("t6_addr", gnt_log[gb:$], 1, 18, 0, 0, 0);
    chk_seq("t6_done", done_log[db:$], 1, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
